pipe_reg_v: RTL and testbench
=============================

// Module: pipe_reg_v
// PURPOSE
//  Parametrised multi-stage pipeline register: WIDTH-bit data plus a valid bit through DEPTH stages.
//  Supports stall (hold), flush (squash), bubble insertion and an occupancy count.
//  Used between datapath stages and as a fixed-latency delay line.
//  Generalises the single enable-gated width-parametrised register to depth, validity and control.
// PARAMETERS
//  WIDTH  64  data bits per stage (>=1)
//  DEPTH  3   number of stages, i.e. latency in cycles (>=1)
// PORTS
//  clk        in   1                    rising-edge clock
//  reset      in   1                    asynchronous, active-high; clears all state
//  stall      in   1                    1 = output stage must not advance
//  flush      in   1                    1 = squash all stages at next edge (sync)
//  in_valid   in   1                    data_in carries a valid item this cycle
//  data_in    in   WIDTH                input data
//  in_ready   out  1                    1 = item on data_in is accepted at this edge
//  out_valid  out  1                    last stage holds a valid item
//  data_out   out  WIDTH                last-stage data
//  count      out  $clog2(DEPTH+1)      number of valid stages
// BEHAVIOUR
//  - Stages s[0..DEPTH-1], each {v, d}. s[0] fed from input; data_out/out_valid = s[DEPTH-1].
//  - reset (async, any time, incl. mid-stall/mid-flush): all v=0, d=0 immediately.
//    So out_valid=0, data_out=0, count=0, in_ready=1.
//  - Bubble rule: a stage loading an invalid item loads d=0. Invalid stage => its d==0.
//  - Priority: reset > flush > stall > normal.
//  - flush=1 at edge: all v=0, d=0. Input on that cycle is dropped regardless of in_valid.
//    in_ready=0 while flush=1. Stall is ignored.
//  - Normal (stall=0, flush=0): every stage shifts (s[i+1]<=s[i]), s[0]<={in_valid,data_in}.
//    in_ready=1. Latency: accepted at edge N -> out_valid/data_out after edge N+DEPTH-1.
//  - Stall behaviour: see CONFIGURATION.
//  - Upstream must hold in_valid/data_in stable while in_ready=0. The block never drops an item
//    except on flush/reset.
//  - count: registered; equals popcount of v[] after each edge. Range 0..DEPTH; no wrap.
//  - No combinational path from data_in to data_out.
//  - in_ready depends combinationally on stall/flush only (plus v[] when the optional feature is on).
// CONFIGURATION
//  PIPE_REG_BUBBLE_COLLAPSE_EN
//   undefined: stall=1 freezes every stage (all hold). in_ready = !stall && !flush.
//   defined:   per-stage advance.
//     adv[DEPTH-1] = !stall.
//     adv[i] = !v[i+1] || adv[i+1].
//     Stage i+1 loads s[i] if adv[i]; otherwise it holds if v[i+1], or loads a bubble.
//     in_ready = (!v[0] || adv[0]) && !flush.
//     Under stall, bubbles ahead of valid items are squeezed out until all stages are valid.
//   Identical behaviour to undefined when stall=0.
// TESTING  (WIDTH=64, DEPTH=3 unless noted)
//  1 reset then in_valid=1 data_in=5000 for 1 cycle, then in_valid=0
//    -> out_valid=1, data_out=5000 for exactly one cycle, 3 cycles after input; count 1,1,1,0.
//  2 stream 1,2,3,4 back-to-back; stall=1 for 2 cycles once 1 reaches output
//    -> data_out holds 1 for 3 cycles, then 2,3,4 in order; nothing lost or duplicated.
//  3 stages full of 10,11,12; assert flush with in_valid=1 data_in=99
//    -> next cycle out_valid=0, data_out=0, count=0; 99 never emerges.
//  4 reset asserted mid-cycle between edges while count=3
//    -> outputs 0 immediately without a clock edge; first post-reset item sees normal 3-cycle latency.
//  5 macro defined: items 7 and bubble,bubble pattern 7,-,8; then stall=1 held
//    -> count rises to 2 without in_ready dropping; in_ready=0 only once count=3.
//    Without the macro, in_ready=0 throughout the stall.
//  6 DEPTH=1 WIDTH=1: toggle data_in each cycle
//    -> data_out equals data_in of previous edge; count in {0,1}.

Source files
------------

// File: rtl/pipe_reg_v.sv
// Multi-stage valid/data pipeline register with stall, flush, bubble squashing and occupancy count.
// Optional per-stage bubble collapsing under stall: define PIPE_REG_BUBBLE_COLLAPSE_EN.
module pipe_reg_v #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] adv;
    logic             take;

    // adv[i]: the item in stage i moves forward at this edge.
    always_comb begin
        adv  = '0;
        take = 1'b0;
`ifdef PIPE_REG_BUBBLE_COLLAPSE_EN
        adv[DEPTH-1] = !stall;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            adv[i] = !v_q[i+1] || adv[i+1];
        end
        take = (!v_q[0] || adv[0]) && !flush;
`else
        adv  = {DEPTH{!stall}};
        take = !stall && !flush;
`endif
    end

    always_comb begin
        v_d     = v_q;
        count_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            d_d[i] = d_q[i];
        end
        if (flush) begin
            v_d = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_d[i] = '0;
            end
        end else begin
            if (take) begin
                v_d[0] = in_valid;
                d_d[0] = in_valid ? data_in : '0;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (adv[i-1]) begin
                    v_d[i] = v_q[i-1];
                    d_d[i] = d_q[i-1];
                end else if (!v_q[i]) begin
                    // Invalid stages always carry zero data.
                    v_d[i] = 1'b0;
                    d_d[i] = '0;
                end
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            count_d = count_d + CW'(v_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign in_ready  = take;
    assign out_valid = v_q[DEPTH-1];
    assign data_out  = d_q[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg_v.sv
// Directed, table-driven bench for pipe_reg_v (DEPTH=3/WIDTH=64 plus a DEPTH=1/WIDTH=1 instance).
module tb_pipe_reg_v;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        in_valid;
        logic [63:0] din;
        logic        rdy;
        logic        ov;
        logic [63:0] dout;
        int          cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, in_valid;
    logic [63:0] data_in;
    logic        in_ready, out_valid;
    logic [63:0] data_out;
    logic [1:0]  count;

    logic        s_in_valid;
    logic [0:0]  s_din;
    logic        s_ready, s_out_valid;
    logic [0:0]  s_dout;
    logic [0:0]  s_count;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_reg_v #(.WIDTH(64), .DEPTH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .data_out  (data_out),
        .count     (count)
    );

    pipe_reg_v #(.WIDTH(1), .DEPTH(1)) dut_small (
        .clk       (clk),
        .reset     (reset),
        .stall     (1'b0),
        .flush     (1'b0),
        .in_valid  (s_in_valid),
        .data_in   (s_din),
        .in_ready  (s_ready),
        .out_valid (s_out_valid),
        .data_out  (s_dout),
        .count     (s_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input logic s, input logic f, input logic iv,
                                input logic [63:0] din, input logic rdy, input logic ov,
                                input logic [63:0] dout, input int cnt);
        vec_t t;
        t.stall = s; t.flush = f; t.in_valid = iv; t.din = din;
        t.rdy = rdy; t.ov = ov; t.dout = dout; t.cnt = cnt;
        return t;
    endfunction

    // Called at posedge+1; drives one cycle and checks ready before and outputs after the edge.
    task automatic apply(input vec_t t, input string tag);
        stall = t.stall; flush = t.flush; in_valid = t.in_valid; data_in = t.din;
        #1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(t.rdy));
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 64'(out_valid), 64'(t.ov));
        check({tag, ".data_out"}, data_out, t.dout);
        check({tag, ".count"}, 64'(count), 64'(t.cnt));
    endtask

    vec_t tv[$];
    vec_t t5[$];
    logic prev;

    initial begin
        reset = 1'b1; stall = 0; flush = 0; in_valid = 0; data_in = '0;
        s_in_valid = 0; s_din = '0;

        // Test 1: single item, bubbles carry junk data that must read as zero
        tv.push_back(mk(0, 0, 1, 5000,     1, 0, 0,    1));
        tv.push_back(mk(0, 0, 0, 64'hDEAD, 1, 0, 0,    1));
        tv.push_back(mk(0, 0, 0, 64'hDEAD, 1, 1, 5000, 1));
        tv.push_back(mk(0, 0, 0, 64'hDEAD, 1, 0, 0,    0));
        // Test 2: stream 1..4, stall 2 cycles once 1 is at the output
        tv.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1));
        tv.push_back(mk(0, 0, 1, 2, 1, 0, 0, 2));
        tv.push_back(mk(0, 0, 1, 3, 1, 1, 1, 3));
        tv.push_back(mk(1, 0, 1, 4, 0, 1, 1, 3));
        tv.push_back(mk(1, 0, 1, 4, 0, 1, 1, 3));
        tv.push_back(mk(0, 0, 1, 4, 1, 1, 2, 3));
        tv.push_back(mk(0, 0, 0, 0, 1, 1, 3, 2));
        tv.push_back(mk(0, 0, 0, 0, 1, 1, 4, 1));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        // Test 3: full of 10,11,12 then flush with 99 on the input
        tv.push_back(mk(0, 0, 1, 10, 1, 0, 0,  1));
        tv.push_back(mk(0, 0, 1, 11, 1, 0, 0,  2));
        tv.push_back(mk(0, 0, 1, 12, 1, 1, 10, 3));
        tv.push_back(mk(0, 1, 1, 99, 0, 0, 0,  0));
        tv.push_back(mk(0, 0, 0, 0,  1, 0, 0,  0));
        tv.push_back(mk(0, 0, 0, 0,  1, 0, 0,  0));
        tv.push_back(mk(0, 0, 0, 0,  1, 0, 0,  0));
        // Flush wins over stall
        tv.push_back(mk(0, 0, 1, 7, 1, 0, 0, 1));
        tv.push_back(mk(1, 1, 1, 5, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));

        // Test 5: 7,-,- then stall held while upstream offers 8,9,10
        t5.push_back(mk(0, 0, 1, 7, 1, 0, 0, 1));
        t5.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
        t5.push_back(mk(0, 0, 0, 0, 1, 1, 7, 1));
`ifdef PIPE_REG_BUBBLE_COLLAPSE_EN
        t5.push_back(mk(1, 0, 1, 8,  1, 1, 7,  2));
        t5.push_back(mk(1, 0, 1, 9,  1, 1, 7,  3));
        t5.push_back(mk(1, 0, 1, 10, 0, 1, 7,  3));
        t5.push_back(mk(0, 0, 1, 10, 1, 1, 8,  3));
        t5.push_back(mk(0, 0, 0, 0,  1, 1, 9,  2));
        t5.push_back(mk(0, 0, 0, 0,  1, 1, 10, 1));
        t5.push_back(mk(0, 0, 0, 0,  1, 0, 0,  0));
`else
        t5.push_back(mk(1, 0, 1, 8,  0, 1, 7,  1));
        t5.push_back(mk(1, 0, 1, 8,  0, 1, 7,  1));
        t5.push_back(mk(1, 0, 1, 8,  0, 1, 7,  1));
        t5.push_back(mk(0, 0, 1, 8,  1, 0, 0,  1));
        t5.push_back(mk(0, 0, 1, 9,  1, 0, 0,  2));
        t5.push_back(mk(0, 0, 1, 10, 1, 1, 8,  3));
        t5.push_back(mk(0, 0, 0, 0,  1, 1, 9,  2));
        t5.push_back(mk(0, 0, 0, 0,  1, 1, 10, 1));
        t5.push_back(mk(0, 0, 0, 0,  1, 0, 0,  0));
`endif

        // Reset state
        @(posedge clk);
        #1;
        check("rst.out_valid", 64'(out_valid), 0);
        check("rst.data_out", data_out, 0);
        check("rst.count", 64'(count), 0);
        check("rst.in_ready", 64'(in_ready), 1);
        check("rst.small_count", 64'(s_count), 0);
        reset = 1'b0;

        foreach (tv[i]) apply(tv[i], $sformatf("main%0d", i));

        // Test 4: async reset between edges while full
        apply(mk(0, 0, 1, 21, 1, 0, 0,  1), "fill0");
        apply(mk(0, 0, 1, 22, 1, 0, 0,  2), "fill1");
        apply(mk(0, 0, 1, 23, 1, 1, 21, 3), "fill2");
        stall = 0; flush = 0; in_valid = 0; data_in = '0;
        #1 reset = 1'b1;
        #1;
        check("arst.out_valid", 64'(out_valid), 0);
        check("arst.data_out", data_out, 0);
        check("arst.count", 64'(count), 0);
        check("arst.in_ready", 64'(in_ready), 1);
        reset = 1'b0;
        apply(mk(0, 0, 1, 42, 1, 0, 0,  1), "post0");
        apply(mk(0, 0, 0, 0,  1, 0, 0,  1), "post1");
        apply(mk(0, 0, 0, 0,  1, 1, 42, 1), "post2");
        apply(mk(0, 0, 0, 0,  1, 0, 0,  0), "post3");

        foreach (t5[i]) apply(t5[i], $sformatf("stall%0d", i));

        // Test 6: DEPTH=1, WIDTH=1 toggling input
        s_in_valid = 1'b1;
        prev = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s_din = k[0];
            #1;
            check("small.in_ready", 64'(s_ready), 1);
            @(posedge clk);
            #1;
            prev = k[0];
            check("small.data_out", 64'(s_dout), 64'(prev));
            check("small.out_valid", 64'(s_out_valid), 1);
            check("small.count", 64'(s_count), 1);
        end
        s_in_valid = 1'b0;
        s_din = 1'b1;
        @(posedge clk);
        #1;
        check("small.drain_count", 64'(s_count), 0);
        check("small.drain_data", 64'(s_dout), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
